// File: rtl/ctrl_loop_cnt_pkg.sv
// Shared widths, state encoding and bounds record for the loop-nest counter.
package ctrl_loop_cnt_pkg;

  localparam int CLOG2K = 3;
  localparam int CLOG2W = 2;
  localparam int CLOG2L = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_cnt_state_t;

  typedef struct packed {
    logic [CLOG2L-1:0] l4;
    logic [CLOG2L-1:0] l3;
    logic [CLOG2L-1:0] l2;
    logic [CLOG2L-1:0] l1;
    logic [CLOG2L-1:0] l0;
    logic [CLOG2W-1:0] ckg;
    logic [CLOG2K-1:0] ksi;
  } ctrl_bounds_t;

endpackage

// File: rtl/ctrl_cnt_stage.sv
// One loop-nest digit: counts 0..bound and wraps to 0 when incremented at its bound.
module ctrl_cnt_stage #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] bound,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign at_max = (cnt_q == bound);
  assign cnt    = cnt_q;

  // Next count: clear wins over increment; increment at bound wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {W{1'b0}};
    end else if (inc) begin
      if (at_max) begin
        cnt_d = {W{1'b0}};
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ctrl_loop_cnt.sv
// Seven-deep loop-nest walker: latches bounds on start, issues every index tuple
// through valid/ready and pulses done after the final tuple is accepted.
module ctrl_loop_cnt
  import ctrl_loop_cnt_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CLOG2K-1:0] arv_KSI,
  input  logic [CLOG2W-1:0] arv_CKG,
  input  logic [CLOG2L-1:0] arv_L0,
  input  logic [CLOG2L-1:0] arv_L1,
  input  logic [CLOG2L-1:0] arv_L2,
  input  logic [CLOG2L-1:0] arv_L3,
  input  logic [CLOG2L-1:0] arv_L4,
  input  logic              ready,
  output logic              valid,
  output logic [CLOG2K-1:0] cnt_KSI,
  output logic [CLOG2W-1:0] cnt_CKG,
  output logic [CLOG2L-1:0] cnt_L0,
  output logic [CLOG2L-1:0] cnt_L1,
  output logic [CLOG2L-1:0] cnt_L2,
  output logic [CLOG2L-1:0] cnt_L3,
  output logic [CLOG2L-1:0] cnt_L4,
  output logic              last,
  output logic              busy,
  output logic              done
);

  ctrl_cnt_state_t state_q;
  ctrl_bounds_t    bounds_q;
  logic            valid_q;
  logic            busy_q;
  logic            done_q;

  logic [6:0] at_max_s;
  logic [6:0] inc_s;
  logic       clr_s;
  logic       adv_s;
  logic       last_s;

  assign clr_s  = (state_q == IDLE) && start;
  assign adv_s  = valid_q && ready;
  // Gated by valid so the all-zero reset state never reports a final tuple.
  assign last_s = valid_q && (&at_max_s);

  // Carry ripple: a stage steps only when every inner stage sits at its bound.
  always_comb begin
    inc_s    = 7'd0;
    inc_s[0] = adv_s;
    for (int n = 1; n < 7; n++) begin
      inc_s[n] = inc_s[n-1] && at_max_s[n-1];
    end
  end

  // Control FSM with registered handshake/status outputs and the bounds latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bounds_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= RUN;
            bounds_q <= '{l4: arv_L4, l3: arv_L3, l2: arv_L2, l1: arv_L1,
                          l0: arv_L0, ckg: arv_CKG, ksi: arv_KSI};
            valid_q  <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        RUN: begin
          if (ready && last_s) begin
            state_q <= DONE;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  ctrl_cnt_stage #(.W(CLOG2K)) u_ksi (.clk(clk), .rst_n(rst_n), .clr(clr_s), .inc(inc_s[0]),
    .bound(bounds_q.ksi), .cnt(cnt_KSI), .at_max(at_max_s[0]));
  ctrl_cnt_stage #(.W(CLOG2W)) u_ckg (.clk(clk), .rst_n(rst_n), .clr(clr_s), .inc(inc_s[1]),
    .bound(bounds_q.ckg), .cnt(cnt_CKG), .at_max(at_max_s[1]));
  ctrl_cnt_stage #(.W(CLOG2L)) u_l0 (.clk(clk), .rst_n(rst_n), .clr(clr_s), .inc(inc_s[2]),
    .bound(bounds_q.l0), .cnt(cnt_L0), .at_max(at_max_s[2]));
  ctrl_cnt_stage #(.W(CLOG2L)) u_l1 (.clk(clk), .rst_n(rst_n), .clr(clr_s), .inc(inc_s[3]),
    .bound(bounds_q.l1), .cnt(cnt_L1), .at_max(at_max_s[3]));
  ctrl_cnt_stage #(.W(CLOG2L)) u_l2 (.clk(clk), .rst_n(rst_n), .clr(clr_s), .inc(inc_s[4]),
    .bound(bounds_q.l2), .cnt(cnt_L2), .at_max(at_max_s[4]));
  ctrl_cnt_stage #(.W(CLOG2L)) u_l3 (.clk(clk), .rst_n(rst_n), .clr(clr_s), .inc(inc_s[5]),
    .bound(bounds_q.l3), .cnt(cnt_L3), .at_max(at_max_s[5]));
  ctrl_cnt_stage #(.W(CLOG2L)) u_l4 (.clk(clk), .rst_n(rst_n), .clr(clr_s), .inc(inc_s[6]),
    .bound(bounds_q.l4), .cnt(cnt_L4), .at_max(at_max_s[6]));

  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign last  = last_s;

endmodule

// File: tb/tb_ctrl_loop_cnt.sv
// Scoreboard bench for ctrl_loop_cnt: expected tuples come from mixed-radix decoding
// of a running index; a negedge monitor pops and compares every accepted tuple.
module tb_ctrl_loop_cnt;
  import ctrl_loop_cnt_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              ready = 1'b0;
  logic [CLOG2K-1:0] arv_KSI = '0;
  logic [CLOG2W-1:0] arv_CKG = '0;
  logic [CLOG2L-1:0] arv_L0 = '0, arv_L1 = '0, arv_L2 = '0, arv_L3 = '0, arv_L4 = '0;
  logic              valid, last, busy, done;
  logic [CLOG2K-1:0] cnt_KSI;
  logic [CLOG2W-1:0] cnt_CKG;
  logic [CLOG2L-1:0] cnt_L0, cnt_L1, cnt_L2, cnt_L3, cnt_L4;

  ctrl_loop_cnt dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .arv_KSI(arv_KSI), .arv_CKG(arv_CKG),
    .arv_L0(arv_L0), .arv_L1(arv_L1), .arv_L2(arv_L2), .arv_L3(arv_L3), .arv_L4(arv_L4),
    .ready(ready), .valid(valid),
    .cnt_KSI(cnt_KSI), .cnt_CKG(cnt_CKG),
    .cnt_L0(cnt_L0), .cnt_L1(cnt_L1), .cnt_L2(cnt_L2), .cnt_L3(cnt_L3), .cnt_L4(cnt_L4),
    .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c[7];
    bit last;
  } tup_t;

  tup_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   acc_cnt = 0;
  int   done_cnt = 0;

  int   dut_v[7];
  int   hold_v[7];
  bit   hold_act = 1'b0;
  bit   hold_last = 1'b0;
  bit   done_exp = 1'b0;
  bit   busy_chk = 1'b0;

  function automatic void chk(string name, int act, int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor: done/busy timing, backpressure stability and tuple scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_act = 1'b0;
      done_exp = 1'b0;
      busy_chk = 1'b0;
    end else begin
      dut_v[0] = int'(cnt_KSI); dut_v[1] = int'(cnt_CKG);
      dut_v[2] = int'(cnt_L0);  dut_v[3] = int'(cnt_L1);  dut_v[4] = int'(cnt_L2);
      dut_v[5] = int'(cnt_L3);  dut_v[6] = int'(cnt_L4);
      if (busy_chk) begin
        chk("busy_after_done", int'(busy), 0);
        busy_chk = 1'b0;
      end
      if (done_exp) begin
        chk("done_pulse", int'(done), 1);
        done_exp = 1'b0;
        busy_chk = 1'b1;
      end else if (done) begin
        chk("spurious_done", int'(done), 0);
      end
      if (done) done_cnt++;
      if (hold_act) begin
        chk("hold_valid", int'(valid), 1);
        for (int i = 0; i < 7; i++) chk("hold_cnt", dut_v[i], hold_v[i]);
        chk("hold_last", int'(last), int'(hold_last));
      end
      if (valid && ready) begin
        hold_act = 1'b0;
        acc_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_tuple", 1, 0);
        end else begin
          tup_t e;
          e = exp_q.pop_front();
          for (int i = 0; i < 7; i++) chk("tuple_cnt", dut_v[i], e.c[i]);
          chk("tuple_last", int'(last), int'(e.last));
          if (e.last) done_exp = 1'b1;
        end
      end else if (valid) begin
        hold_act  = 1'b1;
        hold_v    = dut_v;
        hold_last = last;
      end else begin
        hold_act = 1'b0;
      end
    end
  end

  function automatic logic drive_ready(int mode, int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 3 == 0);
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic set_arv(input int b[7]);
    arv_KSI = CLOG2K'(b[0]); arv_CKG = CLOG2W'(b[1]);
    arv_L0 = CLOG2L'(b[2]); arv_L1 = CLOG2L'(b[3]); arv_L2 = CLOG2L'(b[4]);
    arv_L3 = CLOG2L'(b[5]); arv_L4 = CLOG2L'(b[6]);
  endtask

  task automatic push_expected(input int b[7]);
    int total = 1;
    for (int i = 0; i < 7; i++) total *= b[i] + 1;
    for (int idx = 0; idx < total; idx++) begin
      tup_t t;
      int r = idx;
      for (int i = 0; i < 7; i++) begin
        t.c[i] = r % (b[i] + 1);
        r      = r / (b[i] + 1);
      end
      t.last = (idx == total - 1);
      exp_q.push_back(t);
    end
  endtask

  task automatic pulse_start(input int mode);
    @(posedge clk); #1;
    start = 1'b1;
    ready = drive_ready(mode, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_latency_valid", int'(valid), 1);
  endtask

  task automatic run_nest(input int b[7], input int mode, input bit perturb);
    int d0;
    int cyc;
    int junk[7];
    push_expected(b);
    set_arv(b);
    d0 = done_cnt;
    pulse_start(mode);
    cyc = 1;
    while (done_cnt == d0 && cyc < 5000) begin
      @(posedge clk); #1;
      ready = drive_ready(mode, cyc);
      if (perturb && cyc == 5) begin
        for (int i = 0; i < 7; i++) junk[i] = $urandom_range(0, 1);
        set_arv(junk);
        start = 1'b1;
      end
      if (perturb && cyc == 6) start = 1'b0;
      cyc++;
    end
    chk("done_seen", done_cnt - d0, 1);
    chk("queue_empty", exp_q.size(), 0);
    exp_q.delete();
    ready = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    int b[7];
    int a0;
    int guard;

    #12;
    chk("rst_valid", int'(valid), 0);
    chk("rst_last", int'(last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cnt", int'({cnt_KSI, cnt_CKG, cnt_L0, cnt_L1, cnt_L2, cnt_L3, cnt_L4}), 0);
    @(negedge clk); rst_n = 1'b1;

    b = '{0, 0, 0, 0, 0, 0, 0};
    run_nest(b, 0, 1'b0);
    b = '{1, 2, 0, 0, 0, 0, 0};
    run_nest(b, 0, 1'b0);
    run_nest(b, 1, 1'b0);
    b = '{1, 1, 1, 1, 1, 1, 1};
    run_nest(b, 0, 1'b1);
    run_nest(b, 2, 1'b1);
    for (int n = 0; n < 4; n++) begin
      b[0] = $urandom_range(0, 3);
      b[1] = $urandom_range(0, 2);
      for (int i = 2; i < 7; i++) b[i] = $urandom_range(0, 1);
      run_nest(b, 2, 1'b0);
    end

    // Asynchronous reset after three of six tuples have been accepted.
    b = '{1, 2, 0, 0, 0, 0, 0};
    push_expected(b);
    set_arv(b);
    a0 = acc_cnt;
    pulse_start(0);
    guard = 0;
    while (acc_cnt - a0 < 3 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("reset_point_reached", acc_cnt - a0, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(valid), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_last", int'(last), 0);
    chk("async_rst_cnt", int'({cnt_KSI, cnt_CKG, cnt_L0, cnt_L1, cnt_L2, cnt_L3, cnt_L4}), 0);
    exp_q.delete();
    ready = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    run_nest(b, 0, 1'b0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
